// File: rtl/video_timing_pkg.sv
// Shared video timing constants and delay FSM encoding.
// Used by the input timing tracker and its delay state machine.
package video_timing_pkg;

    localparam int H_ACT = 640;
    localparam int H_FP  = 16;
    localparam int H_SW  = 96;
    localparam int H_BP  = 48;
    localparam int V_ACT = 480;
    localparam int V_FP  = 10;
    localparam int V_SW  = 2;
    localparam int V_BP  = 33;

    localparam int CNT_W_DEF = 12;

    localparam logic [1:0] S_IDLE       = 2'd0;
    localparam logic [1:0] S_WAIT_LINES = 2'd1;
    localparam logic [1:0] S_WAIT_PIX   = 2'd2;
    localparam logic [1:0] S_FIRE       = 2'd3;

    typedef enum logic [1:0] {
        IDLE       = S_IDLE,
        WAIT_LINES = S_WAIT_LINES,
        WAIT_PIX   = S_WAIT_PIX,
        FIRE       = S_FIRE
    } vrst_state_e;

endpackage

// File: rtl/video_input_timing_tracker_if.sv
// Raw video input stream: vertical/horizontal sync and data enable.
// The source drives it through master, the tracker listens via slave.
interface video_input_timing_tracker_if;

    logic I_VSYNC;
    logic I_HSYNC;
    logic I_DE;

    modport master (
        output I_VSYNC,
        output I_HSYNC,
        output I_DE
    );

    modport slave (
        input I_VSYNC,
        input I_HSYNC,
        input I_DE
    );

endinterface

// File: rtl/vrst_delay_fsm.sv
// Delays a frame start by DLY_LINES line ends plus DLY_PIX clocks,
// then emits a one-cycle reset pulse for the timing generator.
module vrst_delay_fsm
    import video_timing_pkg::*;
#(
    parameter int DLY_LINES = 1,
    parameter int DLY_PIX   = 2,
    parameter int CNT_W     = CNT_W_DEF
) (
    input  logic I_PCLK,
    input  logic I_RST,
    input  logic vs_rise,
    input  logic de_fall,
    output logic O_VRST
);

    localparam logic [CNT_W-1:0] LINES = CNT_W'(DLY_LINES);
    localparam logic [CNT_W-1:0] PIX   = CNT_W'(DLY_PIX);

    vrst_state_e      state;
    vrst_state_e      state_n;
    logic [CNT_W-1:0] line_cnt;
    logic [CNT_W-1:0] line_cnt_n;
    logic [CNT_W-1:0] pix_cnt;
    logic [CNT_W-1:0] pix_cnt_n;

    // State and counter registers
    always_ff @(posedge I_PCLK) begin
        if (I_RST) begin
            state    <= IDLE;
            line_cnt <= '0;
            pix_cnt  <= '0;
        end else begin
            state    <= state_n;
            line_cnt <= line_cnt_n;
            pix_cnt  <= pix_cnt_n;
        end
    end

    // Next state; a new frame start restarts from any state
    always_comb begin
        state_n    = state;
        line_cnt_n = line_cnt;
        pix_cnt_n  = pix_cnt;
        if (vs_rise) begin
            if (DLY_LINES == 0) begin
                state_n   = WAIT_PIX;
                pix_cnt_n = '0;
            end else begin
                state_n    = WAIT_LINES;
                line_cnt_n = '0;
            end
        end else begin
            unique case (state)
                WAIT_LINES: begin
                    if (de_fall) begin
                        if (line_cnt + 1'b1 == LINES) begin
                            state_n   = WAIT_PIX;
                            pix_cnt_n = '0;
                        end else begin
                            line_cnt_n = line_cnt + 1'b1;
                        end
                    end
                end
                WAIT_PIX: begin
                    if (pix_cnt == PIX) begin
                        state_n = FIRE;
                    end else begin
                        pix_cnt_n = pix_cnt + 1'b1;
                    end
                end
                FIRE: begin
                    state_n = IDLE;
                end
                IDLE: begin
                    state_n = IDLE;
                end
            endcase
        end
    end

    assign O_VRST = (state == FIRE);

endmodule

// File: rtl/video_input_timing_tracker.sv
// Tracks raw input timing: pixel coordinates, format measurement,
// lock status, and a delayed frame-reset pulse for the output raster.
module video_input_timing_tracker
    import video_timing_pkg::*;
#(
    parameter int HACT      = H_ACT,
    parameter int VACT      = V_ACT,
    parameter int DLY_LINES = 1,
    parameter int DLY_PIX   = 2,
    parameter int CNT_W     = CNT_W_DEF
) (
    input  logic                         I_PCLK,
    input  logic                         I_RST,
    video_input_timing_tracker_if.slave  vin,
    output logic                         O_VRST,
    output logic                         O_DE,
    output logic                         O_HSYNC,
    output logic [CNT_W-1:0]             O_COL,
    output logic [CNT_W-1:0]             O_ROW,
    output logic [CNT_W-1:0]             O_ACT_WIDTH,
    output logic [CNT_W-1:0]             O_ACT_HEIGHT,
    output logic                         O_LOCKED,
    output logic                         O_FMT_ERR
);

    localparam logic [CNT_W-1:0] HACT_C = CNT_W'(HACT);
    localparam logic [CNT_W-1:0] VACT_C = CNT_W'(VACT);
    localparam logic [CNT_W-1:0] CMAX   = {CNT_W{1'b1}};

    logic             vs_q;
    logic             vs_q2;
    logic             hs_q;
    logic             de_q;
    logic             de_q2;
    logic             vs_rise;
    logic             de_fall;
    logic [CNT_W-1:0] col;
    logic [CNT_W-1:0] row;
    logic             width_bad;
    logic             frame_seen;
    logic [1:0]       good_cnt;
    logic             frame_good;

    // Input registers and edge-detect history
    always_ff @(posedge I_PCLK) begin
        if (I_RST) begin
            vs_q  <= 1'b0;
            vs_q2 <= 1'b0;
            hs_q  <= 1'b0;
            de_q  <= 1'b0;
            de_q2 <= 1'b0;
        end else begin
            vs_q  <= vin.I_VSYNC;
            vs_q2 <= vs_q;
            hs_q  <= vin.I_HSYNC;
            de_q  <= vin.I_DE;
            de_q2 <= de_q;
        end
    end

    assign vs_rise = vs_q & ~vs_q2;
    assign de_fall = ~de_q & de_q2;

    // Saturating column and row counters aligned with de_q
    always_ff @(posedge I_PCLK) begin
        if (I_RST) begin
            col <= '0;
            row <= '0;
        end else begin
            if (!de_q) begin
                col <= '0;
            end else if (col != CMAX) begin
                col <= col + 1'b1;
            end
            if (vs_rise) begin
                row <= '0;
            end else if (de_fall && row != CMAX) begin
                row <= row + 1'b1;
            end
        end
    end

    assign frame_good = (row == VACT_C) && !width_bad;

    // Line/frame measurement and lock tracking
    always_ff @(posedge I_PCLK) begin
        if (I_RST) begin
            O_ACT_WIDTH  <= '0;
            O_ACT_HEIGHT <= '0;
            width_bad    <= 1'b0;
            frame_seen   <= 1'b0;
            good_cnt     <= 2'd0;
            O_LOCKED     <= 1'b0;
            O_FMT_ERR    <= 1'b0;
        end else begin
            O_FMT_ERR <= 1'b0;
            if (de_fall) begin
                O_ACT_WIDTH <= col;
                if (col != HACT_C) begin
                    width_bad <= 1'b1;
                end
            end
            if (vs_rise) begin
                O_ACT_HEIGHT <= row;
                width_bad    <= 1'b0;
                frame_seen   <= 1'b1;
                if (frame_seen) begin
                    if (frame_good) begin
                        if (good_cnt != 2'd2) begin
                            good_cnt <= good_cnt + 2'd1;
                        end
                        O_LOCKED <= (good_cnt != 2'd0);
                    end else begin
                        good_cnt  <= 2'd0;
                        O_LOCKED  <= 1'b0;
                        O_FMT_ERR <= 1'b1;
                    end
                end
            end
        end
    end

    assign O_DE    = de_q;
    assign O_HSYNC = hs_q;
    assign O_COL   = col;
    assign O_ROW   = row;

    vrst_delay_fsm #(
        .DLY_LINES (DLY_LINES),
        .DLY_PIX   (DLY_PIX),
        .CNT_W     (CNT_W)
    ) u_dly (
        .I_PCLK  (I_PCLK),
        .I_RST   (I_RST),
        .vs_rise (vs_rise),
        .de_fall (de_fall),
        .O_VRST  (O_VRST)
    );

endmodule

// File: doc/video_input_timing_tracker.md
Name: video_input_timing_tracker

Overview:
- Sits on the I_PCLK input side, in parallel with the buffered 3x3 colorspace converter. It consumes the raw VSYNC/HSYNC/DE stream.
- Produces a frame-reset pulse for the video timing generator. The pulse is delayed by a programmable number of lines plus pixels so the output raster lines up with the Sobel result.
- Also provides registered column/row coordinates and input-format lock/error status.

Parameters:
- HACT, 640, expected active pixels per line
- VACT, 480, expected active lines per frame
- DLY_LINES, 1, active-line ends to wait after VSYNC rise before the pixel delay starts (0 allowed)
- DLY_PIX, 2, additional I_PCLK cycles before O_VRST fires (0 allowed)
- CNT_W, 12, width of all counters

Ports:
- I_PCLK  in  1  pixel clock
- I_RST  in  1  synchronous active-high reset
- I_VSYNC  in  1  input vertical sync, active-high
- I_HSYNC  in  1  input horizontal sync (registered and passed through only)
- I_DE  in  1  input data enable
- O_VRST  out  1  delayed one-cycle frame-reset pulse
- O_DE  out  1  I_DE delayed 1 cycle
- O_HSYNC  out  1  I_HSYNC delayed 1 cycle
- O_COL  out  CNT_W  column of the pixel qualified by O_DE
- O_ROW  out  CNT_W  row of the pixel qualified by O_DE
- O_ACT_WIDTH  out  CNT_W  last measured line width
- O_ACT_HEIGHT  out  CNT_W  last measured frame height
- O_LOCKED  out  1  input format matches HACT x VACT
- O_FMT_ERR  out  1  one-cycle pulse on a format mismatch

Behaviour:
- Reset: I_RST is sampled on the I_PCLK edge, synchronous and active-high. All registers and outputs go to 0 and the FSM goes to IDLE. Reset overrides everything, including a delay in progress.
- Input stage: vs_q, hs_q, de_q are registered from I_VSYNC, I_HSYNC, I_DE.
  - vs_rise = vs_q & ~vs_q2
  - de_fall = ~de_q & de_q2
- Counters:
  - col increments while de_q is high and clears the cycle after de_q falls.
  - O_COL/O_ROW are valid when O_DE=1. The first pixel of a line has O_COL=0.
  - row increments on de_fall and clears on vs_rise.
  - Both counters saturate at 2^CNT_W-1; they never wrap.
- Measurement:
  - On de_fall, O_ACT_WIDTH <= col. If col != HACT, the frame's width_bad flag is set.
  - On vs_rise, O_ACT_HEIGHT <= row.
- Format check on vs_rise, applied only once frame_seen=1 (the first partial frame after reset is ignored):
  - The frame is good when row==VACT and width_bad==0.
  - Good frame: good_cnt increments, saturating at 2. O_LOCKED=1 when good_cnt==2.
  - Bad frame: good_cnt <= 0, O_LOCKED <= 0, and O_FMT_ERR pulses 1 cycle.
  - width_bad clears on vs_rise.
- Delay FSM states are IDLE, WAIT_LINES, WAIT_PIX, FIRE.
  - IDLE --vs_rise--> WAIT_LINES with line_cnt=0, or straight to WAIT_PIX with pix_cnt=0 when DLY_LINES==0.
  - WAIT_LINES: line_cnt increments on each de_fall. When it reaches DLY_LINES it goes to WAIT_PIX with pix_cnt=0.
  - WAIT_PIX: pix_cnt increments each cycle. On the cycle where pix_cnt==DLY_PIX it goes to FIRE.
  - FIRE: O_VRST=1 for exactly one cycle, then IDLE.
- Latency, with edge k being the first edge at which I_VSYNC is sampled high:
  - With DLY_LINES=0, O_VRST is high during the cycle after edge k+2+DLY_PIX.
  - With DLY_LINES>0, timing is measured from the edge where the qualifying de_fall is detected, with the same +1+DLY_PIX.
- Retrigger: a vs_rise in any non-IDLE state restarts the FSM from the WAIT_LINES/WAIT_PIX entry. No pulse is issued for the aborted frame.
- Simultaneous vs_rise and de_fall in WAIT_LINES: vs_rise wins (restart) and the de_fall is not counted.
- VSYNC held high continuously generates only one O_VRST.
- DE never falling after VSYNC with DLY_LINES>0: the FSM stays in WAIT_LINES indefinitely and issues no pulse.

Decomposition:
- Shared package video_timing_pkg holds:
  - the VGA constants (HACT/HFP/HSW/HBP, VACT/VFP/VSW/VBP) and the default CNT_W;
  - the FSM state encoding localparams (IDLE=0, WAIT_LINES=1, WAIT_PIX=2, FIRE=3).
- One sub-module, vrst_delay_fsm, contains the delay state machine with its line/pixel counters. Inputs are vs_rise and de_fall; output is O_VRST.
- Counters, measurement and lock logic stay in the top of this block.

Test Plan:
- Reset held 5 cycles mid-WAIT_PIX, then released -> O_VRST, O_LOCKED, O_COL, O_ROW, O_ACT_* all 0; no stale O_VRST afterwards.
- DLY_LINES=0, DLY_PIX=0, single VSYNC rise sampled at edge 10 -> O_VRST high exactly during cycle 13 (after edge 12), low otherwise; a 100-cycle VSYNC hold yields one pulse.
- Full 640x480 VGA frames, default parameters -> O_COL runs 0..639 per line and O_ROW 0..479. O_VRST fires 3 cycles after the first line's DE falls. O_ACT_WIDTH=640, O_ACT_HEIGHT=480. O_LOCKED rises at the third VSYNC rise (first is ignored, then two good frames).
- Locked stream, then one line with 639 DE cycles -> at the next VSYNC rise O_FMT_ERR pulses 1 cycle, O_LOCKED=0, and O_LOCKED re-asserts two good frames later.
- DLY_LINES=3; second VSYNC rise after 2 lines -> no O_VRST for the aborted frame; pulse arrives after the 3rd DE fall of the new frame plus 1+DLY_PIX.
- DE held high 5000 cycles with CNT_W=12 -> O_COL saturates at 4095 (no wrap), and O_ACT_WIDTH=4095 on the DE fall.
